// File: rtl/ultrasensor_pkg.sv
// ultrasensor_pkg: state encoding, done codes and line-ending characters shared by the measure/report block.
package ultrasensor_pkg;
`ifdef ULTRASENSOR_CRLF_EN
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, SEND, SEND_CR, SEND_LF, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, SEND, DONE} state_t;
`endif
  localparam logic [1:0] DONE_NONE = 2'd0;
  localparam logic [1:0] DONE_NEAR = 2'd1;
  localparam logic [1:0] DONE_CLEAR = 2'd2;
  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_LF = 8'd10;
endpackage

// File: rtl/ultra_settle_timer.sv
// ultra_settle_timer: counts cycles since restart dropped; expired flags the SETTLE_CYCLES-th cycle.
module ultra_settle_timer #(
  parameter int SETTLE_CYCLES = 7000000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic expired
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= restart ? '0 : cnt + CW'(1);
  assign expired = !restart && cnt == CW'(SETTLE_CYCLES - 1);
endmodule

// File: rtl/ultrasensor_measure_report.sv
// ultrasensor_measure_report: take NUM_SAMPLES settled distance samples, keep the minimum, report it as an ASCII digit.
// Build option ULTRASENSOR_CRLF_EN appends CR and LF bytes after the digit.
module ultrasensor_measure_report
  import ultrasensor_pkg::*;
#(
  parameter int DIST_W = 3,
  parameter int NUM_SAMPLES = 4,
  parameter int SETTLE_CYCLES = 7000000,
  parameter int MAX_BIN = 4,
  parameter int ASCII_BASE = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  output logic              busy,
  output logic [1:0]        done_code,
  output logic [DIST_W-1:0] result,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              sensor_on,
  input  logic [DIST_W-1:0] distance
);
  localparam logic [DIST_W-1:0] MAX_V = DIST_W'(MAX_BIN);
  localparam logic [DIST_W-1:0] SAT_V = DIST_W'(MAX_BIN + 1);
  localparam bit SAT_OK = MAX_BIN + 1 <= 2 ** DIST_W - 1;
  localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES - 1);
  localparam logic [7:0] BASE = 8'(ASCII_BASE);
  state_t state, state_n;
  logic [DIST_W-1:0] min_q, min_n, result_n, smp_min;
  logic [7:0] cnt, cnt_n, tx_data_n;
  logic [1:0] code, code_n, done_code_n;
  logic busy_n, tx_valid_n, sensor_on_n, expired, near;
  ultra_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .restart(state != SETTLE),
    .expired(expired)
  );
  assign smp_min = distance < min_q ? distance : min_q;
  assign near = smp_min != '0 && smp_min <= MAX_V;
  always_comb begin
    state_n = state;
    min_n = min_q;
    cnt_n = cnt;
    code_n = code;
    busy_n = busy;
    done_code_n = done_code;
    result_n = result;
    tx_data_n = tx_data;
    tx_valid_n = tx_valid;
    sensor_on_n = sensor_on;
    case (state)
      IDLE: begin
        min_n = '1;
        cnt_n = '0;
        if (start) begin
          state_n = SETTLE;
          busy_n = 1'b1;
          sensor_on_n = 1'b1;
        end
      end
      SETTLE: if (expired) state_n = SAMPLE;
      SAMPLE: begin
        min_n = smp_min;
        if (cnt == LAST_CNT) begin
          state_n = SEND;
          sensor_on_n = 1'b0;
          tx_valid_n = 1'b1;
          tx_data_n = near ? BASE + 8'(smp_min) : BASE;
          code_n = near ? DONE_NEAR : DONE_CLEAR;
          result_n = SAT_OK && smp_min > SAT_V ? SAT_V : smp_min;
        end else begin
          cnt_n = cnt + 8'd1;
          state_n = SETTLE;
        end
      end
`ifdef ULTRASENSOR_CRLF_EN
      SEND: if (tx_ready) begin
        state_n = SEND_CR;
        tx_data_n = ASCII_CR;
      end
      SEND_CR: if (tx_ready) begin
        state_n = SEND_LF;
        tx_data_n = ASCII_LF;
      end
      SEND_LF: if (tx_ready) begin
        state_n = DONE;
        tx_valid_n = 1'b0;
        done_code_n = code;
      end
`else
      SEND: if (tx_ready) begin
        state_n = DONE;
        tx_valid_n = 1'b0;
        done_code_n = code;
      end
`endif
      DONE: if (ack) begin
        state_n = IDLE;
        busy_n = 1'b0;
        done_code_n = DONE_NONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      min_q <= '1;
      cnt <= '0;
      code <= DONE_NONE;
      busy <= 1'b0;
      done_code <= DONE_NONE;
      result <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      sensor_on <= 1'b0;
    end else begin
      state <= state_n;
      min_q <= min_n;
      cnt <= cnt_n;
      code <= code_n;
      busy <= busy_n;
      done_code <= done_code_n;
      result <= result_n;
      tx_data <= tx_data_n;
      tx_valid <= tx_valid_n;
      sensor_on <= sensor_on_n;
    end
endmodule

// File: tb/tb_ultrasensor_measure_report.sv
// tb_ultrasensor_measure_report: randomized measurements checked against a min/classify/byte-list reference model.
module tb_ultrasensor_measure_report;
  localparam int DW = 3, NS = 3, SC = 4, MB = 4, AB = 48;
  localparam int PER = SC + 1;
  logic clk = 0, reset = 0, start = 0, ack = 0, tx_ready = 0;
  logic [DW-1:0] distance = '0;
  logic busy, tx_valid, sensor_on;
  logic [1:0] done_code;
  logic [DW-1:0] result;
  logic [7:0] tx_data;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  ultrasensor_measure_report #(
    .DIST_W(DW), .NUM_SAMPLES(NS), .SETTLE_CYCLES(SC), .MAX_BIN(MB), .ASCII_BASE(AB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .busy(busy),
    .done_code(done_code), .result(result), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sensor_on(sensor_on), .distance(distance)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done_code"}, done_code, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_sensor_on"}, sensor_on, 0);
  endtask
  // hold < 0: tx_ready random; hold >= 0: ready low for hold cycles then high
  task automatic measure(input int s0, input int s1, input int s2, input int hold, input bit ack_start);
    int smp[NS];
    int exp_q[$];
    int mn, code, res, cyc;
    logic [7:0] held;
    smp = '{s0, s1, s2};
    mn = smp[0];
    foreach (smp[i]) if (smp[i] < mn) mn = smp[i];
    code = (mn >= 1 && mn <= MB) ? 1 : 2;
    res = (MB + 1 < (1 << DW) && mn > MB + 1) ? MB + 1 : mn;
    exp_q.push_back(code == 1 ? AB + mn : AB);
`ifdef ULTRASENSOR_CRLF_EN
    exp_q.push_back(13);
    exp_q.push_back(10);
`endif
    start = 1;
    distance = DW'($urandom_range(0, 7));
    tick;
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("sensor_on_after_start", sensor_on, 1);
    cyc = 0;
    while (!tx_valid && cyc < 200) begin
      distance = DW'(((cyc + 1) % PER == 0 && cyc / PER < NS) ? smp[cyc / PER] : int'($urandom_range(0, 7)));
      tx_ready = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      tick;
      cyc++;
    end
    start = 0;
    ack = 0;
    chk("first_valid_latency", cyc, NS * PER);
    chk("sensor_off_in_send", sensor_on, 0);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      tx_ready = cyc < hold ? 1'b0 : (hold >= 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      held = tx_data;
      chk("tx_valid_held", tx_valid, 1);
      if (tx_ready && tx_valid) chk("tx_byte", tx_data, exp_q.pop_front());
      tick;
      cyc++;
      if (!tx_ready) chk("tx_data_stable", tx_data, held);
    end
    chk("bytes_left", exp_q.size(), 0);
    tx_ready = 1'($urandom_range(0, 1));
    chk("valid_low_in_done", tx_valid, 0);
    chk("done_code", done_code, code);
    chk("result", result, res);
    chk("busy_in_done", busy, 1);
    start = 1;
    tick;
    start = 0;
    tick;
    chk("done_ignores_start", done_code, code);
    chk("sensor_off_in_done", sensor_on, 0);
    ack = 1;
    start = ack_start;
    tick;
    ack = 0;
    start = 0;
    chk("done_cleared_on_ack", done_code, 0);
    chk("idle_after_ack", busy, 0);
    tick;
    tick;
    chk("no_rearm_from_ack_start", busy, 0);
    chk("sensor_idle", sensor_on, 0);
  endtask
  initial begin
    repeat (2) tick;
    chk_reset_values("por");
    @(negedge clk) reset = 1;
    tick;
    measure(3, 2, 4, 0, 0);
    measure(0, 0, 0, -1, 1);
    measure(6, 7, 5, 10, 0);
    measure(1, 1, 1, -1, 0);
    measure(7, 7, 7, -1, 1);
    start = 1;
    tick;
    start = 0;
    repeat (PER + 2) tick;
    chk("busy_before_abort", busy, 1);
    #2 reset = 0;
    #1 chk_reset_values("async_abort");
    @(negedge clk) reset = 1;
    tick;
    measure(2, 5, 3, 0, 0);
    for (int k = 0; k < 8; k++)
      measure($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
